// File: rtl/omsp_sm_slot_manager.sv
// Protected-module slot table: create/destroy command port with a sequential
// one-slot-per-cycle overlap scan, plus current/previous executing ID tracking.
module omsp_sm_slot_manager #(
    parameter int unsigned NB_SLOTS   = 4,
    parameter int unsigned ID_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  mclk,
    input  logic                  puc_rst,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  handling_irq,
    input  logic [3:0]            irq_num,
    input  logic                  cmd_valid,
    input  logic                  cmd_op,
    input  logic [ADDR_WIDTH-1:0] pub_start,
    input  logic [ADDR_WIDTH-1:0] pub_end,
    input  logic [ADDR_WIDTH-1:0] sec_start,
    input  logic [ADDR_WIDTH-1:0] sec_end,
    output logic                  cmd_ready,
    output logic                  rsp_valid,
    output logic                  rsp_ok,
    output logic [ID_WIDTH-1:0]   rsp_id,
    output logic [NB_SLOTS-1:0]   slots_enabled,
    output logic [ID_WIDTH-1:0]   current_id,
    output logic [ID_WIDTH-1:0]   prev_id,
    output logic                  id_exhausted
);

    localparam int unsigned IdxW = (NB_SLOTS > 1) ? $clog2(NB_SLOTS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NB_SLOTS - 1);
    localparam logic [ID_WIDTH-1:0] IrqIdBase = {{(ID_WIDTH - 4){1'b1}}, 4'b0000};

    typedef enum logic [1:0] {StIdle, StScan, StCommit, StResp} state_e;

    state_e                state_q;
    logic                  rsp_valid_q, rsp_ok_q, exh_q, hit_q;
    logic [ID_WIDTH-1:0]   rsp_id_q, next_id_q, prev_cyc_q, prev_id_q;
    logic [IdxW-1:0]       scan_idx_q, tgt_q;
    logic [NB_SLOTS-1:0]   en_q;
    logic [ADDR_WIDTH-1:0] pub_s_q [NB_SLOTS];
    logic [ADDR_WIDTH-1:0] pub_e_q [NB_SLOTS];
    logic [ADDR_WIDTH-1:0] sec_s_q [NB_SLOTS];
    logic [ADDR_WIDTH-1:0] sec_e_q [NB_SLOTS];
    logic [ID_WIDTH-1:0]   id_q    [NB_SLOTS];
    logic [ADDR_WIDTH-1:0] n_pub_s_q, n_pub_e_q, n_sec_s_q, n_sec_e_q;

    // Half-open overlap; an empty range never overlaps anything.
    function automatic logic overlap(input logic [ADDR_WIDTH-1:0] as, ae, bs, be);
        return (as < ae) && (bs < be) && (as < be) && (bs < ae);
    endfunction

    logic                free_found, dest_found, imm_fail, scan_hit;
    logic [IdxW-1:0]     free_idx, dest_idx;
    logic [ID_WIDTH-1:0] cur_id, next_id_inc;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        cur_id     = '0;
        for (int i = 0; i < NB_SLOTS; i++) begin
            if (!en_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
            if (en_q[i] && pub_s_q[i] <= pc && pc < pub_e_q[i]) cur_id = id_q[i];
        end
        if (handling_irq) cur_id = {IrqIdBase[ID_WIDTH-1:4], irq_num};
    end

    always_comb begin
        dest_found = 1'b0;
        dest_idx   = '0;
        for (int i = 0; i < NB_SLOTS; i++) begin
            if (en_q[i] && cur_id != '0 && id_q[i] == cur_id) begin
                dest_found = 1'b1;
                dest_idx   = IdxW'(i);
            end
        end
    end

    assign imm_fail = (pub_start >= pub_end) || (sec_start > sec_end) ||
                      overlap(pub_start, pub_end, sec_start, sec_end) || !free_found || exh_q;

    assign scan_hit = en_q[scan_idx_q] &&
        (overlap(n_pub_s_q, n_pub_e_q, pub_s_q[scan_idx_q], pub_e_q[scan_idx_q]) ||
         overlap(n_pub_s_q, n_pub_e_q, sec_s_q[scan_idx_q], sec_e_q[scan_idx_q]) ||
         overlap(n_sec_s_q, n_sec_e_q, pub_s_q[scan_idx_q], pub_e_q[scan_idx_q]) ||
         overlap(n_sec_s_q, n_sec_e_q, sec_s_q[scan_idx_q], sec_e_q[scan_idx_q]));

    assign next_id_inc = next_id_q + ID_WIDTH'(1);

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            rsp_ok_q    <= 1'b0;
            rsp_id_q    <= '0;
            en_q        <= '0;
            next_id_q   <= ID_WIDTH'(1);
            exh_q       <= 1'b0;
            hit_q       <= 1'b0;
            scan_idx_q  <= '0;
            tgt_q       <= '0;
            n_pub_s_q   <= '0;
            n_pub_e_q   <= '0;
            n_sec_s_q   <= '0;
            n_sec_e_q   <= '0;
            for (int i = 0; i < NB_SLOTS; i++) begin
                pub_s_q[i] <= '0;
                pub_e_q[i] <= '0;
                sec_s_q[i] <= '0;
                sec_e_q[i] <= '0;
                id_q[i]    <= '0;
            end
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        if (cmd_op) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_ok_q    <= dest_found;
                            rsp_id_q    <= dest_found ? cur_id : '0;
                            if (dest_found) en_q[dest_idx] <= 1'b0;
                        end else if (imm_fail) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_ok_q    <= 1'b0;
                            rsp_id_q    <= '0;
                        end else begin
                            state_q    <= StScan;
                            tgt_q      <= free_idx;
                            scan_idx_q <= '0;
                            hit_q      <= 1'b0;
                            n_pub_s_q  <= pub_start;
                            n_pub_e_q  <= pub_end;
                            n_sec_s_q  <= sec_start;
                            n_sec_e_q  <= sec_end;
                        end
                    end
                end
                StScan: begin
                    hit_q <= hit_q | scan_hit;
                    if (scan_idx_q == LastIdx) state_q <= StCommit;
                    else scan_idx_q <= scan_idx_q + IdxW'(1);
                end
                // Scan failures also pass through here so create latency is fixed.
                StCommit: begin
                    state_q     <= StResp;
                    rsp_valid_q <= 1'b1;
                    if (!hit_q) begin
                        pub_s_q[tgt_q] <= n_pub_s_q;
                        pub_e_q[tgt_q] <= n_pub_e_q;
                        sec_s_q[tgt_q] <= n_sec_s_q;
                        sec_e_q[tgt_q] <= n_sec_e_q;
                        id_q[tgt_q]    <= next_id_q;
                        en_q[tgt_q]    <= 1'b1;
                        next_id_q      <= next_id_inc;
                        if (next_id_inc == IrqIdBase) exh_q <= 1'b1;
                        rsp_ok_q       <= 1'b1;
                        rsp_id_q       <= next_id_q;
                    end else begin
                        rsp_ok_q <= 1'b0;
                        rsp_id_q <= '0;
                    end
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            prev_cyc_q <= '0;
            prev_id_q  <= '0;
        end else begin
            prev_cyc_q <= cur_id;
            if (prev_cyc_q != cur_id) prev_id_q <= prev_cyc_q;
        end
    end

    assign cmd_ready     = (state_q == StIdle);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_ok        = rsp_ok_q;
    assign rsp_id        = rsp_id_q;
    assign slots_enabled = en_q;
    assign current_id    = cur_id;
    assign prev_id       = prev_id_q;
    assign id_exhausted  = exh_q;

endmodule
